ahb_sram_slave: RTL and testbench

//  AHB-Lite SRAM slave with programmable wait states. It sits downstream of the master-side

---
 rtl/ahb_sram_slave_if.sv | 25 ++
 rtl/ahb_sram_slave.sv | 64 ++++++
 tb/tb_ahb_sram_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite slave-side bus bundle (address/control, write data, response).
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hmastlock;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [15:0] hsplit;
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hmastlock, hready,
    input  hreadyout, hresp, hrdata, hsplit
  );
  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hmastlock, hready,
    output hreadyout, hresp, hrdata, hsplit
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic             hclk,
  input logic             hreset,
  ahb_sram_slave_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;
  logic [2:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        size_q;
  logic              write_q, err_q;
  logic              ready, acc, a_err;
  logic [3:0]        be;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rword, wword;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused;
  assign unused = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.haddr[31:ADDR_W+2]};
  assign ready  = state != S_WAIT && state != S_ERR1;
  assign acc    = bus.hsel & bus.hready & bus.htrans[1] & ready;
  assign a_err  = (bus.hsize > 3'b010) || (bus.hsize == 3'b001 && bus.haddr[0]) ||
                  (bus.hsize == 3'b010 && bus.haddr[1:0] != 2'b00);
  assign widx   = addr_q[ADDR_W+1:2];
  assign rword  = mem[widx];
  // little-endian lanes: byte lane from addr[1:0], halfword lane from addr[1]
  assign be     = size_q == 3'b000 ? 4'b0001 << addr_q[1:0] :
                  size_q == 3'b001 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wword  = {be[3] ? bus.hwdata[31:24] : rword[31:24],
                   be[2] ? bus.hwdata[23:16] : rword[23:16],
                   be[1] ? bus.hwdata[15:8]  : rword[15:8],
                   be[0] ? bus.hwdata[7:0]   : rword[7:0]};
  assign bus.hreadyout = ready;
  assign bus.hresp     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
  assign bus.hrdata    = (state == S_DATA && !write_q) ? rword : 32'h0;
  assign bus.hsplit    = 16'h0000;
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      size_q  <= 3'b000;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (acc) begin
        addr_q  <= bus.haddr[ADDR_W+1:0];
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
        err_q   <= a_err;
      end
      state <= acc ? (a_err ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA) :
               state == S_WAIT ? (cnt == 4'd0 ? S_DATA : S_WAIT) :
               state == S_ERR1 ? S_ERR2 : S_IDLE;
      cnt   <= acc ? 4'(WAIT_STATES - 1) : (state == S_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    end
  // write data arrives in the data phase, so commit on the edge that ends DATA
  always_ff @(posedge hclk)
    if (state == S_DATA && write_q && !err_q)
      mem[widx] <= wword;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: table-driven and randomized checks of ahb_sram_slave against a byte-level memory model.
module tb_ahb_sram_slave;
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] rmask;
  } xfer_t;

  localparam logic [1:0] ID = 2'b00, BS = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic        hclk = 1'b0, hreset = 1'b1;
  logic        sel = 1'b0, wr = 1'b0;
  logic [1:0]  trans = 2'b00;
  logic [2:0]  size = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  int          dsel = 0;
  int          errors = 0, checks = 0;
  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rdata;
  xfer_t       q[$];
  xfer_t       tbl0[20];
  xfer_t       tbl1[12];
  logic [7:0]  rm[2][4096];
  bit          kn[2][4096];

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus1();

  assign bus0.hsel = sel & (dsel == 0);
  assign bus1.hsel = sel & (dsel == 1);
  assign bus0.haddr = addr;      assign bus1.haddr = addr;
  assign bus0.htrans = trans;    assign bus1.htrans = trans;
  assign bus0.hwrite = wr;       assign bus1.hwrite = wr;
  assign bus0.hsize = size;      assign bus1.hsize = size;
  assign bus0.hburst = 3'b011;   assign bus1.hburst = 3'b011;
  assign bus0.hprot = 4'b0011;   assign bus1.hprot = 4'b0011;
  assign bus0.hwdata = wdata;    assign bus1.hwdata = wdata;
  assign bus0.hmastlock = 1'b0;  assign bus1.hmastlock = 1'b0;
  assign bus0.hready = bus0.hreadyout;
  assign bus1.hready = bus1.hreadyout;
  assign rdy   = dsel == 1 ? bus1.hreadyout : bus0.hreadyout;
  assign resp  = dsel == 1 ? bus1.hresp : bus0.hresp;
  assign rdata = dsel == 1 ? bus1.hrdata : bus0.hrdata;

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(1)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0.slave));
  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1.slave));

  always #5 hclk = ~hclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic s, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd, input logic e, input logic [31:0] rd);
    xfer_t t;
    t.sel = s; t.trans = tr; t.wr = w; t.size = sz; t.addr = a; t.wdata = wd;
    t.err = e; t.rdata = rd; t.rmask = '1;
    return t;
  endfunction

  // byte-addressed memory: a transfer is a run of 1/2/4 bytes at its offset modulo 4 KiB
  function automatic xfer_t model(input int d, input xfer_t t);
    int off, nb;
    off = int'(t.addr[11:0]);
    t.err = t.sel && t.trans[1] && ((t.size > 3'b010) || (t.size == 3'b001 && t.addr[0]) ||
                                    (t.size == 3'b010 && t.addr[1:0] != 2'b00));
    t.rdata = '0;
    t.rmask = '0;
    if (!t.sel || !t.trans[1] || t.err) return t;
    nb = t.size == 3'b000 ? 1 : t.size == 3'b001 ? 2 : 4;
    if (t.wr) begin
      for (int i = 0; i < nb; i++) begin
        rm[d][off+i] = t.wdata[8*((off+i)%4) +: 8];
        kn[d][off+i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        t.rdata[8*i +: 8] = rm[d][(off & ~3) + i];
        t.rmask[8*i +: 8] = kn[d][(off & ~3) + i] ? 8'hFF : 8'h00;
      end
    end
    return t;
  endfunction

  function automatic void add_tbl(input int d, input xfer_t t);
    void'(model(d, t));
    q.push_back(t);
  endfunction

  task automatic drive(input int i);
    if (i < q.size()) begin
      sel = q[i].sel; trans = q[i].trans; wr = q[i].wr; size = q[i].size; addr = q[i].addr;
    end else begin
      sel = 1'b0; trans = ID; wr = 1'b0; size = 3'b000; addr = 32'h0;
    end
  endtask

  // pipelined master: address of entry ap overlaps data phase of entry dp
  task automatic run_q(input int ws);
    int ap = 0, dp = -1, dc = 0, guard = 0;
    logic r, nul, xr;
    logic [1:0] xresp;
    drive(0);
    while ((ap < q.size() || dp >= 0) && guard < 5000) begin
      @(negedge hclk);
      r = rdy;
      if (dp >= 0) begin
        nul   = !(q[dp].sel && q[dp].trans[1]);
        xr    = nul ? 1'b1 : q[dp].err ? (dc > 0) : (dc >= ws);
        xresp = (!nul && q[dp].err) ? 2'b01 : 2'b00;
        chk($sformatf("ready_resp x%0d c%0d", dp, dc), {29'b0, rdy, resp}, {29'b0, xr, xresp});
        if (!nul && !q[dp].err && !q[dp].wr && xr)
          chk($sformatf("rdata x%0d @%h", dp, q[dp].addr), rdata & q[dp].rmask, q[dp].rdata & q[dp].rmask);
        else
          chk($sformatf("rdata_zero x%0d c%0d", dp, dc), rdata, 32'h0);
      end
      @(posedge hclk);
      #1;
      if (r) begin
        dp = ap < q.size() ? ap : -1;
        if (ap < q.size()) ap++;
        dc = 0;
        drive(ap);
        wdata = dp >= 0 ? q[dp].wdata : 32'h0;
      end else dc++;
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d cycles expected fewer than 5000", guard);
    end
    q.delete();
  endtask

  initial begin
    tbl0[0]  = mk(1, NS, 1, 3'd2, 32'h10,   32'hDEADBEEF, 0, 0);
    tbl0[1]  = mk(1, NS, 1, 3'd2, 32'h20,   32'hCAFEF00D, 0, 0);
    tbl0[2]  = mk(1, NS, 0, 3'd2, 32'h10,   0,            0, 32'hDEADBEEF);
    tbl0[3]  = mk(1, NS, 1, 3'd0, 32'h11,   32'h0000AA00, 0, 0);
    tbl0[4]  = mk(1, NS, 0, 3'd2, 32'h10,   0,            0, 32'hDEADAAEF);
    tbl0[5]  = mk(1, NS, 1, 3'd1, 32'h12,   32'h12340000, 0, 0);
    tbl0[6]  = mk(1, NS, 0, 3'd2, 32'h10,   0,            0, 32'h1234AAEF);
    tbl0[7]  = mk(1, NS, 1, 3'd2, 32'h12,   32'hFFFFFFFF, 1, 0);
    tbl0[8]  = mk(1, NS, 1, 3'd3, 32'h20,   32'hFFFFFFFF, 1, 0);
    tbl0[9]  = mk(1, NS, 0, 3'd2, 32'h10,   0,            0, 32'h1234AAEF);
    tbl0[10] = mk(1, NS, 0, 3'd2, 32'h20,   0,            0, 32'hCAFEF00D);
    tbl0[11] = mk(0, NS, 1, 3'd2, 32'h10,   32'h11111111, 0, 0);
    tbl0[12] = mk(1, ID, 1, 3'd2, 32'h10,   32'h22222222, 0, 0);
    tbl0[13] = mk(1, BS, 1, 3'd2, 32'h10,   32'h33333333, 0, 0);
    tbl0[14] = mk(0, ID, 1, 3'd2, 32'h20,   32'h44444444, 0, 0);
    tbl0[15] = mk(1, ID, 1, 3'd0, 32'h11,   32'h55555555, 0, 0);
    tbl0[16] = mk(1, NS, 0, 3'd2, 32'h10,   0,            0, 32'h1234AAEF);
    tbl0[17] = mk(1, NS, 1, 3'd2, 32'h1000, 32'h0BADC0DE, 0, 0);
    tbl0[18] = mk(1, NS, 0, 3'd2, 32'h0,    0,            0, 32'h0BADC0DE);
    tbl0[19] = mk(1, NS, 0, 3'd2, 32'h20,   0,            0, 32'hCAFEF00D);
    tbl1[0]  = mk(1, NS, 1, 3'd2, 32'h40, 32'h1, 0, 0);
    tbl1[1]  = mk(1, SQ, 1, 3'd2, 32'h44, 32'h2, 0, 0);
    tbl1[2]  = mk(1, SQ, 1, 3'd2, 32'h48, 32'h3, 0, 0);
    tbl1[3]  = mk(1, SQ, 1, 3'd2, 32'h4C, 32'h4, 0, 0);
    tbl1[4]  = mk(1, NS, 0, 3'd2, 32'h40, 0, 0, 32'h1);
    tbl1[5]  = mk(1, SQ, 0, 3'd2, 32'h44, 0, 0, 32'h2);
    tbl1[6]  = mk(1, SQ, 0, 3'd2, 32'h48, 0, 0, 32'h3);
    tbl1[7]  = mk(1, SQ, 0, 3'd2, 32'h4C, 0, 0, 32'h4);
    tbl1[8]  = mk(1, NS, 1, 3'd2, 32'h50, 32'h77, 0, 0);
    tbl1[9]  = mk(1, NS, 0, 3'd2, 32'h50, 0, 0, 32'h77);
    tbl1[10] = mk(1, NS, 1, 3'd0, 32'h53, 32'hAB000000, 0, 0);
    tbl1[11] = mk(1, NS, 0, 3'd2, 32'h50, 0, 0, 32'hAB000077);

    #3;
    chk("reset ready0", 32'(bus0.hreadyout), 32'h1);
    chk("reset resp0", 32'(bus0.hresp), 32'h0);
    chk("reset rdata0", bus0.hrdata, 32'h0);
    chk("reset ready1", 32'(bus1.hreadyout), 32'h1);
    chk("hsplit0", 32'(bus0.hsplit), 32'h0);
    chk("hsplit1", 32'(bus1.hsplit), 32'h0);
    @(posedge hclk);
    @(posedge hclk);
    #3 hreset = 1'b0;

    dsel = 0;
    foreach (tbl0[i]) add_tbl(0, tbl0[i]);
    run_q(1);
    dsel = 1;
    foreach (tbl1[i]) add_tbl(1, tbl1[i]);
    run_q(0);

    // reset during the wait state of a write drops the write
    dsel = 0;
    add_tbl(0, mk(1, NS, 1, 3'd2, 32'h30, 32'h55AA1234, 0, 0));
    run_q(1);
    sel = 1'b1; trans = NS; wr = 1'b1; size = 3'd2; addr = 32'h30;
    @(posedge hclk);
    #1;
    sel = 1'b0; trans = ID; wdata = 32'hFFFFFFFF;
    @(negedge hclk);
    chk("mid_wait ready", 32'(rdy), 32'h0);
    #2 hreset = 1'b1;
    #1;
    chk("async_reset ready", 32'(rdy), 32'h1);
    chk("async_reset resp", 32'(resp), 32'h0);
    chk("async_reset rdata", rdata, 32'h0);
    @(posedge hclk);
    #3 hreset = 1'b0;
    add_tbl(0, mk(1, NS, 0, 3'd2, 32'h30, 0, 0, 32'h55AA1234));
    run_q(1);

    for (int d = 0; d < 2; d++) begin
      dsel = d;
      for (int n = 0; n < 150; n++) begin
        xfer_t t;
        int sz;
        t.sel   = $urandom_range(0, 9) != 0;
        t.trans = $urandom_range(0, 7) < 6 ? {1'b1, 1'($urandom)} : 2'($urandom_range(0, 1));
        t.wr    = 1'($urandom);
        sz      = $urandom_range(0, 9);
        t.size  = sz < 3 ? 3'd0 : sz < 5 ? 3'd1 : sz < 8 ? 3'd2 : sz == 8 ? 3'd3 : 3'($urandom_range(4, 7));
        t.addr  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0)
          t.addr = t.addr & ~(t.size == 3'd1 ? 32'h1 : t.size == 3'd2 ? 32'h3 : 32'h0);
        t.wdata = $urandom;
        q.push_back(model(d, t));
      end
      run_q(d == 0 ? 1 : 0);
    end

    chk("final hsplit0", 32'(bus0.hsplit), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
